sha256_final_add_compare: RTL and testbench
===========================================

Name: sha256_final_add_compare

Overview:
- Downstream neighbour of the last SHA-256 round stage (round 64). Each cycle it takes the final working-variable set {a..h} plus the chaining value that seeded the 64 rounds.
- Adds the two word-wise mod 2^32 to form the digest, then runs a mining target check on the digest.
- Buffers the nonce of every passing digest in a small FIFO, drained by the controller over a valid/ready handshake.
- Also keeps a hash counter, a drop counter and a sticky overflow flag.

Parameters:
- FIFO_DEPTH, 4, number of hit-nonce entries (power of two, 2..16).
- NONCE_W, 32, nonce width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_state/in_h0/in_nonce qualify this cycle
- in_state  input  256  final round variables {a,b,c,d,e,f,g,h}, a in [255:224]
- in_h0  input  256  chaining value {H0..H7}, H0 in [255:224]
- in_nonce  input  NONCE_W  nonce tagged to this hash
- target_h6  input  32  threshold for byte-swapped digest word 6; quasi-static
- flush  input  1  synchronous clear of pipeline, FIFO and overflow flag
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_nonce  output  NONCE_W  FIFO head nonce
- digest_valid  output  1  digest register updated last edge
- digest  output  256  last computed digest {D0..D7}
- hash_count  output  32  valid inputs processed, wraps
- drop_count  output  8  hits lost to full FIFO, saturates at 8'hFF
- overflow  output  1  sticky: at least one hit dropped

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; FIFO empty; internal valids 0; pointers 0.

Stage 1 (edge after input sampled):
- Di = in_state word i + in_h0 word i, mod 2^32, for i = 0..7.
- digest and nonce1 load only when in_valid = 1.
- digest_valid <= in_valid.
- hash_count increments on in_valid and wraps from FFFFFFFF to 0.

Stage 2 (next edge):
- hit <= digest_valid & (D7 == 0) & (bswap32(D6) <= target_h6), unsigned compare.
- bswap32 reverses byte order: bytes [31:24] and [7:0] swap; bytes [23:16] and [15:8] swap.
- nonce2 <= nonce1.

Stage 3 (next edge):
- If hit, push nonce2 into the FIFO.
- Total latency: in_valid sampled at edge E0 gives out_valid high after E2 when the FIFO was empty.
- Back-to-back hits every cycle are supported.

FIFO:
- out_nonce is the head entry; out_valid = not empty.
- A pop occurs on out_valid & out_ready.
- Full with a pop and a push on the same edge: both occur and nothing is dropped.
- Full with a push and no pop: the entry is discarded, drop_count increments (saturating) and overflow <= 1.
- Empty: out_ready is ignored and out_nonce holds its last value.
- Pointers wrap modulo FIFO_DEPTH. Occupancy count ranges 0..FIFO_DEPTH.

Flush:
- Priority over push and pop.
- Clears the FIFO, digest_valid, stage-2 hit and overflow.
- drop_count and hash_count are NOT cleared; only reset clears them.
- Inputs presented on the flush edge are discarded.

Other rules:
- Reset asserted mid-operation: all in-flight hits are lost and outputs return to reset values immediately.
- target_h6 is sampled by stage 2. A change takes effect for the digest already in stage 1.
- No handshake on the input side: the block accepts every cycle, matching the round pipeline.

Test Plan:
- Reset release; in_state = 0, in_h0 = {6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19}, in_valid one cycle -> digest equals in_h0 after one edge; no hit; out_valid stays 0; hash_count = 1.
- in_h0 = 0, in_state word g = 00000001, h = 0, target_h6 = 01000000, nonce = 0000ABCD -> out_valid rises exactly 3 edges after input; out_nonce = 0000ABCD. Same with target_h6 = 00FFFFFF -> no hit.
- Carry wrap: state word a = FFFFFFFF, H0 = 00000002 -> D0 = 00000001.
- Six consecutive hits (nonces 1..6), out_ready = 0, FIFO_DEPTH = 4 -> FIFO holds 1..4; drop_count = 2; overflow = 1. Then out_ready = 1 -> pops 1,2,3,4 on consecutive edges, then out_valid = 0.
- FIFO full, out_ready = 1 and a new hit arriving on the same edge -> pop and push both occur; drop_count unchanged; occupancy stays 4.
- flush while the FIFO holds 2 entries and a hit is in stage 2 -> next cycle out_valid = 0 and overflow = 0; drop_count and hash_count retained. Assert reset_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sha256_final_add_compare.sv
// SHA-256 feed-forward add and mining target check; hit nonces queue in a small FIFO for the controller.
// Latency: input edge E0 -> digest after E0 -> hit after E1 -> out_valid after E2; input always accepted, hits into a full FIFO are dropped and counted.

module sha256_hit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_drop,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [W-1:0]  last_dat;
  logic          empty, full, do_push, do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_vld   = !empty;
  assign do_pop    = pop_vld & pop_rdy & !clr;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push   = push_vld & !clr & (!full | do_pop);
  assign push_drop = push_vld & !clr & full & !do_pop;
  // When empty the output keeps showing whatever it showed last cycle.
  assign pop_dat   = empty ? last_dat : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_dat <= '0;
    end else begin
      last_dat <= pop_dat;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

module sha256_final_add_compare #(
  parameter int FIFO_DEPTH = 4,
  parameter int NONCE_W    = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [255:0]       in_state,
  input  logic [255:0]       in_h0,
  input  logic [NONCE_W-1:0] in_nonce,
  input  logic [31:0]        target_h6,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NONCE_W-1:0] out_nonce,
  output logic               digest_valid,
  output logic [255:0]       digest,
  output logic [31:0]        hash_count,
  output logic [7:0]         drop_count,
  output logic               overflow
);
  logic [255:0]       sum;
  logic [31:0]        d6, d7, d6_swap;
  logic [NONCE_W-1:0] nonce1, nonce2;
  logic               hit;
  logic               push_drop;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) sum[i*32 +: 32] = in_state[i*32 +: 32] + in_h0[i*32 +: 32];
  end

  assign d6      = digest[63:32];
  assign d7      = digest[31:0];
  assign d6_swap = {d6[7:0], d6[15:8], d6[23:16], d6[31:24]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digest_valid <= 1'b0;
      digest       <= '0;
      nonce1       <= '0;
      hash_count   <= '0;
    end else if (flush) begin
      digest_valid <= 1'b0;
    end else begin
      digest_valid <= in_valid;
      if (in_valid) begin
        digest     <= sum;
        nonce1     <= in_nonce;
        hash_count <= hash_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit    <= 1'b0;
      nonce2 <= '0;
    end else begin
      hit    <= !flush & digest_valid & (d7 == 32'd0) & (d6_swap <= target_h6);
      nonce2 <= nonce1;
    end
  end

  sha256_hit_fifo #(.DEPTH(FIFO_DEPTH), .W(NONCE_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (flush),
    .push_vld  (hit),
    .push_dat  (nonce2),
    .push_drop (push_drop),
    .pop_vld   (out_valid),
    .pop_rdy   (out_ready),
    .pop_dat   (out_nonce)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (flush)          overflow <= 1'b0;
      else if (push_drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sha256_final_add_compare.sv
// Directed and random bench for sha256_final_add_compare against a transaction-level queue model.
module tb_sha256_final_add_compare;
  localparam int DEPTH = 4;
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         v = 1'b0, fl = 1'b0, rdy = 1'b0;
  logic [255:0] st = '0, h0 = '0;
  logic [31:0]  nn = '0, tgt = '0;
  logic         out_valid, digest_valid, overflow;
  logic [31:0]  out_nonce, hash_count;
  logic [255:0] digest;
  logic [7:0]   drop_count;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0]  mq[$];
  int           pend_due[$];
  logic [31:0]  pend_n[$];
  int           edge_k = 0;
  logic [31:0]  m_hc = 0, m_last = 0;
  logic [7:0]   m_drop = 0;
  logic         m_ovf = 0, m_dv = 0;
  logic [255:0] m_dig = '0;

  always #5 clk = ~clk;

  sha256_final_add_compare #(.FIFO_DEPTH(DEPTH), .NONCE_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(v), .in_state(st), .in_h0(h0),
    .in_nonce(nn), .target_h6(tgt), .flush(fl), .out_valid(out_valid),
    .out_ready(rdy), .out_nonce(out_nonce), .digest_valid(digest_valid),
    .digest(digest), .hash_count(hash_count), .drop_count(drop_count),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] digest_of(input logic [255:0] s, input logic [255:0] h);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = s[255-32*i -: 32] + h[255-32*i -: 32];
    return r;
  endfunction

  function automatic bit is_hit(input logic [255:0] d, input logic [31:0] t);
    logic [31:0] w6, w7, sw;
    w6 = d[255-32*6 -: 32];
    w7 = d[255-32*7 -: 32];
    sw = {w6[7:0], w6[15:8], w6[23:16], w6[31:24]};
    return (w7 == 32'd0) && (sw <= t);
  endfunction

  task automatic model_reset();
    mq.delete(); pend_due.delete(); pend_n.delete();
    m_hc = 0; m_last = 0; m_drop = 0; m_ovf = 0; m_dv = 0; m_dig = '0;
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_nonce", out_nonce, (mq.size() > 0) ? mq[0] : m_last);
    chk("drop_count", drop_count, m_drop);
    chk("overflow", overflow, m_ovf);
    chk("hash_count", hash_count, m_hc);
    chk("digest_valid", digest_valid, m_dv);
    chk("digest", digest, m_dig);
  endtask

  // One clock edge: the model applies the same inputs, then every output is compared.
  task automatic cyc();
    logic [31:0] n;
    @(posedge clk);
    edge_k++;
    m_last = (mq.size() > 0) ? mq[0] : m_last;
    if (fl) begin
      mq.delete(); pend_due.delete(); pend_n.delete();
      m_ovf = 1'b0;
      m_dv  = 1'b0;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (pend_due.size() > 0 && pend_due[0] == edge_k) begin
        void'(pend_due.pop_front());
        n = pend_n.pop_front();
        if (mq.size() < DEPTH) mq.push_back(n);
        else begin
          if (m_drop != 8'hFF) m_drop++;
          m_ovf = 1'b1;
        end
      end
      m_dv = v;
      if (v) begin
        m_hc++;
        m_dig = digest_of(st, h0);
        if (is_hit(m_dig, tgt)) begin
          pend_due.push_back(edge_k + 2);
          pend_n.push_back(nn);
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic rand_cycles(input int n, input int rdy_pct);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 8; i++) begin
        st[i*32 +: 32] = $urandom();
        h0[i*32 +: 32] = $urandom();
      end
      if ($urandom_range(0, 3) != 0) h0[31:0] = ~st[31:0] + 32'd1;
      v   = ($urandom_range(0, 3) != 0);
      nn  = $urandom();
      rdy = ($urandom_range(0, 99) < rdy_pct);
      fl  = ($urandom_range(0, 31) == 0);
      cyc();
    end
    v = 1'b0; fl = 1'b0; rdy = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_nonce", out_nonce, 0);
    chk("rst_digest", digest, 0);
    chk("rst_hash_count", hash_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_digest_valid", digest_valid, 0);
    @(negedge clk) reset_n = 1'b1;

    // zero state plus IV: digest equals IV, no hit
    v = 1; st = '0; h0 = IV; nn = 32'h77; tgt = 32'h0;
    cyc();
    chk("iv_digest", digest, IV);
    chk("iv_count", hash_count, 1);
    v = 0;
    repeat (3) cyc();
    chk("iv_nohit", out_valid, 0);

    // target boundary hit and three-edge latency
    h0 = '0; st = '0; st[63:32] = 32'h1; tgt = 32'h0100_0000; nn = 32'h0000_ABCD; v = 1;
    cyc(); chk("lat_e0", out_valid, 0);
    v = 0;
    cyc(); chk("lat_e1", out_valid, 0);
    cyc(); chk("lat_e2", out_valid, 1); chk("lat_nonce", out_nonce, 32'h0000_ABCD);
    rdy = 1; cyc(); rdy = 0;
    chk("pop_to_empty", out_valid, 0);
    chk("hold_nonce", out_nonce, 32'h0000_ABCD);
    tgt = 32'h00FF_FFFF; nn = 32'h1234; v = 1;
    cyc(); v = 0;
    repeat (3) cyc();
    chk("tgt_miss", out_valid, 0);

    // carry wrap in word 0
    st = '0; st[255:224] = 32'hFFFF_FFFF; h0 = '0; h0[255:224] = 32'h2; h0[31:0] = 32'h1; v = 1;
    cyc(); v = 0;
    chk("carry_d0", digest[255:224], 32'h1);

    // six back-to-back hits into a 4-deep FIFO
    st = '0; st[63:32] = 32'h1; h0 = '0; tgt = 32'h0100_0000; rdy = 0;
    for (int n = 1; n <= 6; n++) begin
      nn = n; v = 1; cyc();
    end
    v = 0;
    repeat (2) cyc();
    chk("six_head", out_nonce, 1);
    chk("six_drop", drop_count, 2);
    chk("six_ovf", overflow, 1);
    rdy = 1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_head", out_nonce, k);
      chk("drain_vld", out_valid, 1);
      cyc();
    end
    rdy = 0;
    chk("drain_empty", out_valid, 0);

    // full FIFO: pop and push on the same edge
    for (int n = 11; n <= 14; n++) begin
      nn = n; v = 1; cyc();
    end
    v = 0;
    repeat (2) cyc();
    nn = 15; v = 1; cyc();
    v = 0; cyc();
    rdy = 1; cyc(); rdy = 0;
    chk("pp_drop", drop_count, 2);
    chk("pp_head", out_nonce, 12);
    rdy = 1;
    for (int k = 12; k <= 15; k++) begin
      chk("pp_drain", out_nonce, k);
      cyc();
    end
    rdy = 0;
    chk("pp_empty", out_valid, 0);

    // flush with two queued entries, a hit in stage 2 and a hit on the flush edge
    for (int n = 21; n <= 22; n++) begin
      nn = n; v = 1; cyc();
    end
    v = 0;
    repeat (2) cyc();
    nn = 23; v = 1; cyc();
    v = 0; cyc();
    nn = 24; v = 1; fl = 1; cyc();
    v = 0; fl = 0;
    chk("flush_vld", out_valid, 0);
    chk("flush_ovf", overflow, 0);
    chk("flush_drop", drop_count, 2);
    chk("flush_hc", hash_count, 18);
    repeat (3) cyc();
    chk("flush_lost", out_valid, 0);

    // random traffic against the model
    tgt = 32'h8000_0000;
    rand_cycles(200, 25);
    rand_cycles(200, 75);

    // asynchronous reset mid-stream
    rand_cycles(20, 10);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_nonce", out_nonce, 0);
    chk("arst_digest", digest, 0);
    chk("arst_hash_count", hash_count, 0);
    chk("arst_drop_count", drop_count, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_digest_valid", digest_valid, 0);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    rand_cycles(100, 50);
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
